// File: rtl/up_counter_w_limit_pkg.sv
// Shared types and defaults for the limited up-counter.
package up_counter_w_limit_pkg;

    localparam int DW_DEF  = 4;
    localparam int MAX_DEF = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/up_counter_w_limit_if.sv
// Control/status bundle between a counter client and the counter.
interface up_counter_w_limit_if
    import up_counter_w_limit_pkg::*;
#(
    parameter int DW = DW_DEF
);

    logic          en;
    logic          start;
    logic          oneshot;
    logic          limit_sel;
    logic [DW-1:0] limit;
    logic [DW-1:0] outCount;
    logic          comparison;
    logic          busy;
    logic          done;

    modport master (
        output en, start, oneshot, limit_sel, limit,
        input  outCount, comparison, busy, done
    );

    modport slave (
        input  en, start, oneshot, limit_sel, limit,
        output outCount, comparison, busy, done
    );

endinterface

// File: rtl/up_counter_w_limit.sv
// Up-counter with selectable terminal value, free-running or oneshot.
module up_counter_w_limit
    import up_counter_w_limit_pkg::*;
#(
    parameter int          DW  = DW_DEF,
    parameter logic [DW-1:0] MAX = DW'(MAX_DEF)
) (
    input logic                clk,
    input logic                rst,
    up_counter_w_limit_if.slave bus
);

    state_e        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic          busy_q, done_q;
    logic [DW-1:0] lim;
    logic          cmp;

    assign lim = bus.limit_sel ? bus.limit : MAX;

    // >= rather than == so a limit lowered below the count still terminates
    assign cmp = (state_q == RUN) & bus.en & (cnt_q >= lim);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    mode_d  = bus.oneshot;
                end
            end
            RUN: begin
                if (bus.start) begin
                    cnt_d  = '0;
                    mode_d = bus.oneshot;
                end else if (cmp) begin
                    if (mode_q) state_d = DONE;
                    else        cnt_d   = '0;
                end else if (bus.en) begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                mode_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.outCount   = cnt_q;
    assign bus.comparison = cmp;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_up_counter_w_limit.sv
// Directed bench with a cycle-level reference model of the counter.
module tb_up_counter_w_limit;

    localparam int DW  = 4;
    localparam int MAX = 9;

    logic clk;
    logic rst;

    up_counter_w_limit_if #(.DW(DW)) bus ();

    up_counter_w_limit #(.DW(DW), .MAX(4'd9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: 0 = IDLE, 1 = RUN, 2 = DONE
    int m_state = 0;
    int m_cnt   = 0;
    bit m_mode  = 1'b0;

    function automatic int eff_limit();
        return bus.limit_sel ? int'(bus.limit) : MAX;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_state <= 0;
            m_cnt   <= 0;
            m_mode  <= 1'b0;
        end else if (bus.start) begin
            m_state <= 1;
            m_cnt   <= 0;
            m_mode  <= bus.oneshot;
        end else if (m_state == 1 && bus.en) begin
            if (m_cnt >= eff_limit()) begin
                if (m_mode) m_state <= 2;
                else        m_cnt   <= 0;
            end else begin
                m_cnt <= (m_cnt + 1) % (1 << DW);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_cnt",  int'(bus.outCount), m_cnt);
            chk("model_busy", int'(bus.busy), int'(m_state == 1));
            chk("model_done", int'(bus.done), int'(m_state == 2));
            chk("model_cmp",  int'(bus.comparison),
                int'(m_state == 1 && bus.en && m_cnt >= eff_limit()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pulses;

    initial begin
        rst           = 1'b1;
        bus.en        = 1'b1;
        bus.start     = 1'b1;
        bus.oneshot   = 1'b0;
        bus.limit_sel = 1'b0;
        bus.limit     = '0;
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_cnt",  int'(bus.outCount), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        rst       = 1'b0;
        bus.en    = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("rst_cmp", int'(bus.comparison), 0);

        // free-running with MAX
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.en    = 1'b1;
        pulses    = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.comparison) begin
                pulses++;
                chk("free_cmp_at", int'(bus.outCount), 9);
            end
            tick();
        end
        chk("free_pulses", pulses, 2);
        chk("free_end_cnt", int'(bus.outCount), 5);

        // oneshot with runtime limit 3
        bus.en        = 1'b0;
        bus.limit_sel = 1'b1;
        bus.limit     = 4'd3;
        bus.oneshot   = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.oneshot = 1'b0;
        bus.en      = 1'b1;
        pulses      = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.comparison) pulses++;
            tick();
        end
        chk("oneshot_pulses", pulses, 1);
        for (int i = 0; i < 10; i++) begin
            chk("oneshot_hold", int'(bus.outCount), 3);
            chk("oneshot_done", int'(bus.done), 1);
            tick();
        end

        // restart from DONE
        bus.limit = 4'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("redo_busy", int'(bus.busy), 1);
        chk("redo_done", int'(bus.done), 0);
        chk("redo_cnt",  int'(bus.outCount), 0);

        // limit lowered below the count
        for (int i = 0; i < 5; i++) tick();
        chk("drop_cnt5", int'(bus.outCount), 5);
        bus.limit = 4'd2;
        #1;
        chk("drop_cmp", int'(bus.comparison), 1);
        tick();
        chk("drop_wrap", int'(bus.outCount), 0);

        // start beats en mid-count
        bus.limit_sel = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("restart_cnt4", int'(bus.outCount), 4);
        bus.start = 1'b1;
        #1;
        chk("restart_cmp", int'(bus.comparison), 0);
        tick();
        bus.start = 1'b0;
        chk("restart_cnt0", int'(bus.outCount), 0);

        // zero limit
        bus.limit_sel = 1'b1;
        bus.limit     = 4'd0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("zero_cmp", int'(bus.comparison), 1);
            chk("zero_cnt", int'(bus.outCount), 0);
            tick();
        end

        // reset mid-RUN
        bus.limit_sel = 1'b0;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("abort_cnt6", int'(bus.outCount), 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_cnt",  int'(bus.outCount), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_cmp",  int'(bus.comparison), 0);
        for (int i = 0; i < 3; i++) tick();
        chk("abort_idle_cnt",  int'(bus.outCount), 0);
        chk("abort_idle_busy", int'(bus.busy), 0);

        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
